// File: rtl/cpu_pkg.sv
// Shared datapath types and constants
// for the 8-bit RISC core.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam data_t ACC_RESET_VALUE = '0;

endpackage

// File: rtl/acc_flags.sv
// Zero / negative / parity status of a word.
// Purely combinational; also usable for ALU status.
module acc_flags
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_parity
);

  // Status flags derived from the value only
  always_comb begin
    o_zero   = (i_value == '0);
    o_neg    = i_value[WIDTH-1];
    o_parity = ^i_value;
  end

endmodule

// File: rtl/accumulator.sv
// CPU accumulator: loads the ALU result on enable,
// exposes registered flags and a one-cycle load strobe.
module accumulator
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(ACC_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_acc_in,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc_out,
  output logic             acc_zero,
  output logic             acc_neg,
  output logic             acc_parity,
  output logic             acc_updated
);

  logic [WIDTH-1:0] r_acc;
  logic             r_updated;
  logic             w_load;

  // Only a definite 1 loads; X/Z on the enable holds
  assign w_load = (en_acc_in === 1'b1);

  // Accumulator register and load strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= RESET_VALUE;
      r_updated <= 1'b0;
    end else begin
      r_updated <= w_load;
      if (w_load) begin
        r_acc <= alu_result;
      end
    end
  end

  assign acc_out     = r_acc;
  assign acc_updated = r_updated;

  acc_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .i_value  (r_acc),
    .o_zero   (acc_zero),
    .o_neg    (acc_neg),
    .o_parity (acc_parity)
  );

endmodule

// File: tb/tb_accumulator.sv
// Self-checking bench for accumulator:
// directed cases then random loads, holds and resets.
module tb_accumulator;

  logic       clk;
  logic       reset;
  logic       en_acc_in;
  logic [7:0] alu_result;
  logic [7:0] acc_out;
  logic       acc_zero;
  logic       acc_neg;
  logic       acc_parity;
  logic       acc_updated;

  int total;
  int bad;

  logic [7:0] exp_acc;
  logic       exp_upd;

  accumulator dut (
    .clk         (clk),
    .reset       (reset),
    .en_acc_in   (en_acc_in),
    .alu_result  (alu_result),
    .acc_out     (acc_out),
    .acc_zero    (acc_zero),
    .acc_neg     (acc_neg),
    .acc_parity  (acc_parity),
    .acc_updated (acc_updated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int ones;
    ones = $countones(exp_acc);
    chk({tag, ".acc"}, 32'(acc_out), 32'(exp_acc));
    chk({tag, ".zero"}, 32'(acc_zero), 32'(exp_acc == 8'd0));
    chk({tag, ".neg"}, 32'(acc_neg), 32'(exp_acc >= 8'd128));
    chk({tag, ".par"}, 32'(acc_parity), 32'(ones % 2));
    chk({tag, ".upd"}, 32'(acc_updated), 32'(exp_upd));
  endtask

  // Drive inputs, take one edge, advance model, check
  task automatic step(
    input string      tag,
    input logic       en,
    input logic [7:0] d
  );
    en_acc_in  = en;
    alu_result = d;
    @(posedge clk);
    #1;
    if (!reset) begin
      exp_acc = 8'h00;
      exp_upd = 1'b0;
    end else if (en) begin
      exp_acc = d;
      exp_upd = 1'b1;
    end else begin
      exp_upd = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset   = 1'b0;
    #1;
    exp_acc = 8'h00;
    exp_upd = 1'b0;
    check_all(tag);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    en_acc_in  = 1'b0;
    alu_result = 8'h00;
    exp_acc    = 8'h00;
    exp_upd    = 1'b0;

    #2;
    check_all("rst0");
    step("rst_edge", 1'b1, 8'h77);
    reset = 1'b1;

    step("ld55", 1'b1, 8'h55);
    step("holdAA", 1'b0, 8'hAA);
    step("ldF0", 1'b1, 8'hF0);

    en_acc_in  = 1'b1;
    alu_result = 8'h3C;
    async_reset("midrst");
    step("rst_hold", 1'b1, 8'h3C);
    reset = 1'b1;

    step("ffA", 1'b1, 8'hFF);
    step("ffB", 1'b1, 8'hFF);
    step("ffC", 1'b1, 8'hFF);
    step("ld00", 1'b1, 8'h00);
    step("ld80", 1'b1, 8'h80);
    step("ld01", 1'b1, 8'h01);

    for (int i = 0; i < 300; i++) begin
      logic       en;
      logic [7:0] d;
      en = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        en_acc_in  = en;
        alu_result = d;
        async_reset("rnd_rst");
        step("rnd_rhold", en, d);
        reset = 1'b1;
      end else begin
        step("rnd", en, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
